// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: effective address, req/gnt/rvalid data-memory handshake,
// store lane alignment, load extraction and writeback with a gnt/rvalid timeout.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        rd_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stall_o,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_wr_en_o,
    output logic              misaligned_o,
    output logic              bus_err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_MISAL = 3'd4;
    localparam logic [2:0] S_ABORT = 3'd5;

    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_tmo;
    logic              w_accept;
    logic              w_misal;
    logic [DATA_W-1:0] w_ea;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_lane;
    logic [DATA_W-1:0] w_load_data;

    logic              r_is_load;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [1:0]        r_ea_lo;
    logic [4:0]        r_rd;

    logic              r_ready;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [DATA_W-1:0] r_dmem_addr;
    logic [3:0]        r_dmem_be;
    logic [DATA_W-1:0] r_dmem_wdata;
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_wr_en;
    logic              r_misal;
    logic              r_bus_err;

    // Request decode: address, alignment check, lane-aligned byte enables and store data
    always_comb begin
        w_ea     = rs1_data_i + imm_i;
        w_accept = req_valid_i && (r_state == S_IDLE) && (is_load_i || is_store_i);
        w_misal  = 1'b0;
        w_be     = 4'b0000;
        w_wdata  = '0;
        case (size_i)
            2'b00: begin
                w_be    = 4'b0001 << w_ea[1:0];
                w_wdata = {4{rs2_data_i[7:0]}};
            end
            2'b01: begin
                w_misal = w_ea[0];
                w_be    = w_ea[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rs2_data_i[15:0]}};
            end
            2'b10: begin
                w_misal = |w_ea[1:0];
                w_be    = 4'b1111;
                w_wdata = rs2_data_i;
            end
            default: w_misal = 1'b1;
        endcase
        if (is_load_i) begin
            w_wdata = '0;
        end
    end

    assign w_tmo = TMO_EN && (r_cnt == CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_misal ? S_MISAL : S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_gnt_i) begin
                    w_next = S_WAIT;
                end else if (w_tmo) begin
                    w_next = S_ABORT;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    w_next = S_RESP;
                end else if (w_tmo) begin
                    w_next = S_ABORT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Load extraction: shift the addressed lane down, then sign/zero extend
    always_comb begin
        w_lane = dmem_rdata_i >> {r_ea_lo, 3'b000};
        case (r_size)
            2'b00:   w_load_data = {{24{~r_unsigned & w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load_data = {{16{~r_unsigned & w_lane[15]}}, w_lane[15:0]};
            default: w_load_data = w_lane;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Timeout counter: cleared while idle and on gnt, counts every REQ/WAIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == S_IDLE) || ((r_state == S_REQ) && dmem_gnt_i)) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_load  <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_ea_lo    <= 2'b00;
            r_rd       <= 5'd0;
        end else if (w_accept) begin
            r_is_load  <= is_load_i;
            r_size     <= size_i;
            r_unsigned <= unsigned_i;
            r_ea_lo    <= w_ea[1:0];
            r_rd       <= rd_i;
        end
    end

    // Registered outputs, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready      <= 1'b1;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_be    <= 4'b0000;
            r_dmem_wdata <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= '0;
            r_wb_wr_en   <= 1'b0;
            r_misal      <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_ready    <= (w_next == S_IDLE);
            r_wb_valid <= (w_next == S_RESP) || (w_next == S_MISAL) || (w_next == S_ABORT);
            r_misal    <= (w_next == S_MISAL);
            r_bus_err  <= (w_next == S_ABORT);

            if (w_accept && !w_misal) begin
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= !is_load_i;
                r_dmem_addr  <= {w_ea[DATA_W-1:2], 2'b00};
                r_dmem_be    <= w_be;
                r_dmem_wdata <= w_wdata;
            end else if (w_next != S_REQ) begin
                r_dmem_req   <= 1'b0;
                r_dmem_we    <= 1'b0;
                r_dmem_addr  <= '0;
                r_dmem_be    <= 4'b0000;
                r_dmem_wdata <= '0;
            end

            if (w_next == S_RESP) begin
                r_wb_rd    <= r_rd;
                r_wb_data  <= r_is_load ? w_load_data : '0;
                r_wb_wr_en <= r_is_load && (r_rd != 5'd0);
            end else begin
                r_wb_rd    <= 5'd0;
                r_wb_data  <= '0;
                r_wb_wr_en <= 1'b0;
            end
        end
    end

    // Stall asserts in the accept cycle itself so execute holds the op it just presented
    assign stall_o      = (r_state == S_REQ) || (r_state == S_WAIT) || w_accept;
    assign req_ready_o  = r_ready;
    assign dmem_req_o   = r_dmem_req;
    assign dmem_we_o    = r_dmem_we;
    assign dmem_addr_o  = r_dmem_addr;
    assign dmem_be_o    = r_dmem_be;
    assign dmem_wdata_o = r_dmem_wdata;
    assign wb_valid_o   = r_wb_valid;
    assign wb_rd_o      = r_wb_rd;
    assign wb_data_o    = r_wb_data;
    assign wb_wr_en_o   = r_wb_wr_en;
    assign misaligned_o = r_misal;
    assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized self-checking bench for lsu_mem_stage against an arithmetic reference model.
module tb_lsu_mem_stage;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        is_load_i;
    logic        is_store_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic [4:0]  rd_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_wr_en_o;
    logic        misaligned_o;
    logic        bus_err_o;

    int n_checks = 0;
    int n_errors = 0;

    lsu_mem_stage #(.TIMEOUT_CYCLES(TMO), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .is_load_i(is_load_i), .is_store_i(is_store_i),
        .size_i(size_i), .unsigned_i(unsigned_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rd_i(rd_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .wb_wr_en_o(wb_wr_en_o),
        .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: byte-count and byte-offset arithmetic straight from the access rules
    function automatic void ref_model(input bit ld, input logic [1:0] sz, input bit uns,
                                      input logic [31:0] rs1, input logic [31:0] imm,
                                      input logic [31:0] rs2, input logic [31:0] rdata,
                                      output bit misal, output logic [31:0] addr,
                                      output logic [3:0] be, output logic [31:0] wdata,
                                      output logic [31:0] data);
        logic [31:0] ea;
        int unsigned off;
        int unsigned nb;
        logic [63:0] v;
        logic [63:0] mask;
        ea    = rs1 + imm;
        off   = ea % 4;
        nb    = (sz == 2'd3) ? 0 : (1 << sz);
        misal = (nb == 0) ? 1'b1 : ((ea % nb) != 0);
        addr  = ea - off;
        be    = 4'(((1 << nb) - 1) << off);
        if (sz == 2'd0)      wdata = (rs2 & 32'hFF) * 32'h01010101;
        else if (sz == 2'd1) wdata = (rs2 & 32'hFFFF) * 32'h00010001;
        else                 wdata = rs2;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = ({32'h0, rdata} >> (8 * off)) & mask;
        if (!uns && nb > 0 && nb < 4 && v[8*nb-1]) v = v | ~mask;
        data = ld ? v[31:0] : 32'h0;
    endfunction

    task automatic idle_inputs();
        req_valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
        size_i = 2'b00; unsigned_i = 1'b0; rd_i = 5'd0;
        rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    endtask

    task automatic run_txn(input string nm, input bit ld, input bit st, input logic [1:0] sz,
                           input bit uns, input logic [31:0] rs1, input logic [31:0] imm,
                           input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdata,
                           input int gd, input int rdly, input bit stray);
        bit          e_misal;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        ref_model(ld, sz, uns, rs1, imm, rs2, rdata, e_misal, e_addr, e_be, e_wdata, e_data);

        @(negedge clk);
        req_valid_i = 1'b1; is_load_i = ld; is_store_i = st; size_i = sz; unsigned_i = uns;
        rs1_data_i = rs1; imm_i = imm; rs2_data_i = rs2; rd_i = rd;
        #1;
        check_eq({nm, "_ready"}, 32'(req_ready_o), 32'd1);
        check_eq({nm, "_stall_acc"}, 32'(stall_o), 32'd1);
        @(negedge clk);
        idle_inputs();

        if (e_misal) begin
            check_eq({nm, "_misal"}, 32'(misaligned_o), 32'd1);
            check_eq({nm, "_misal_wbv"}, 32'(wb_valid_o), 32'd1);
            check_eq({nm, "_misal_wren"}, 32'(wb_wr_en_o), 32'd0);
            check_eq({nm, "_misal_req"}, 32'(dmem_req_o), 32'd0);
            check_eq({nm, "_misal_stall"}, 32'(stall_o), 32'd0);
            @(negedge clk);
            check_eq({nm, "_misal_end"}, 32'(misaligned_o | wb_valid_o), 32'd0);
            check_eq({nm, "_misal_idle"}, 32'(req_ready_o), 32'd1);
            return;
        end

        for (int i = 0; i <= gd; i++) begin
            if (i > 0) @(negedge clk);
            check_eq({nm, "_req"}, 32'(dmem_req_o), 32'd1);
            check_eq({nm, "_addr"}, dmem_addr_o, e_addr);
            check_eq({nm, "_be"}, 32'(dmem_be_o), 32'(e_be));
            check_eq({nm, "_we"}, 32'(dmem_we_o), 32'(!ld));
            if (!ld) check_eq({nm, "_wdata"}, dmem_wdata_o, e_wdata);
            check_eq({nm, "_stall_req"}, 32'(stall_o), 32'd1);
            check_eq({nm, "_busy"}, 32'(req_ready_o), 32'd0);
        end
        dmem_gnt_i = 1'b1;
        if (stray) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = ~rdata;
        end
        @(negedge clk);
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        check_eq({nm, "_req_drop"}, 32'(dmem_req_o), 32'd0);
        check_eq({nm, "_stall_wait"}, 32'(stall_o), 32'd1);
        check_eq({nm, "_wbv_wait"}, 32'(wb_valid_o), 32'd0);
        repeat (rdly) begin
            @(negedge clk);
            check_eq({nm, "_wbv_wait"}, 32'(wb_valid_o), 32'd0);
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        @(negedge clk);
        dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
        check_eq({nm, "_wbv"}, 32'(wb_valid_o), 32'd1);
        check_eq({nm, "_wbdata"}, wb_data_o, e_data);
        check_eq({nm, "_wren"}, 32'(wb_wr_en_o), 32'(ld && rd != 5'd0));
        if (ld) check_eq({nm, "_wbrd"}, 32'(wb_rd_o), 32'(rd));
        check_eq({nm, "_stall_resp"}, 32'(stall_o), 32'd0);
        check_eq({nm, "_err"}, 32'(misaligned_o | bus_err_o), 32'd0);
        @(negedge clk);
        check_eq({nm, "_wbv_pulse"}, 32'(wb_valid_o), 32'd0);
        check_eq({nm, "_back_idle"}, 32'(req_ready_o), 32'd1);
    endtask

    task automatic issue_lw();
        @(negedge clk);
        req_valid_i = 1'b1; is_load_i = 1'b1; size_i = 2'b10;
        rs1_data_i = 32'h4000; imm_i = 32'h8; rd_i = 5'd7;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic tmo_case(input bit in_wait);
        issue_lw();
        if (in_wait) begin
            dmem_gnt_i = 1'b1;
            @(negedge clk);
            dmem_gnt_i = 1'b0;
        end
        for (int i = 0; i < int'(TMO); i++) begin
            if (i > 0) @(negedge clk);
            check_eq("tmo_pending_err", 32'(bus_err_o), 32'd0);
            check_eq("tmo_pending_req", 32'(dmem_req_o), 32'(!in_wait));
            check_eq("tmo_pending_stall", 32'(stall_o), 32'd1);
        end
        @(negedge clk);
        check_eq("tmo_bus_err", 32'(bus_err_o), 32'd1);
        check_eq("tmo_wbv", 32'(wb_valid_o), 32'd1);
        check_eq("tmo_wren", 32'(wb_wr_en_o), 32'd0);
        check_eq("tmo_req", 32'(dmem_req_o), 32'd0);
        check_eq("tmo_stall", 32'(stall_o), 32'd0);
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
        repeat (3) begin
            @(negedge clk);
            check_eq("late_wbv", 32'(wb_valid_o), 32'd0);
            check_eq("late_err", 32'(bus_err_o), 32'd0);
            check_eq("late_ready", 32'(req_ready_o), 32'd1);
        end
        idle_inputs();
    endtask

    task automatic rst_case(input bit in_wait);
        issue_lw();
        if (in_wait) begin
            dmem_gnt_i = 1'b1;
            @(negedge clk);
            dmem_gnt_i = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check_eq("rst_req", 32'(dmem_req_o), 32'd0);
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        check_eq("rst_wbv", 32'(wb_valid_o), 32'd0);
        check_eq("rst_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
        repeat (3) begin
            @(negedge clk);
            check_eq("stray_wbv", 32'(wb_valid_o), 32'd0);
            check_eq("stray_req", 32'(dmem_req_o), 32'd0);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("reset_ready", 32'(req_ready_o), 32'd1);
        check_eq("reset_outs", 32'({dmem_req_o, dmem_we_o, stall_o, wb_valid_o, wb_wr_en_o,
                                     misaligned_o, bus_err_o}), 32'd0);
        check_eq("reset_bus", dmem_addr_o | dmem_wdata_o | 32'(dmem_be_o), 32'd0);
        check_eq("reset_wb", wb_data_o | 32'(wb_rd_o), 32'd0);
        rst = 1'b0;

        // Neither op bit set: must be ignored
        @(negedge clk);
        req_valid_i = 1'b1;
        #1 check_eq("noop_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        idle_inputs();
        check_eq("noop_ready", 32'(req_ready_o), 32'd1);
        check_eq("noop_req", 32'(dmem_req_o), 32'd0);

        run_txn("lw",    1, 0, 2'b10, 0, 32'h1000, 32'h4, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        run_txn("lb",    1, 0, 2'b00, 0, 32'h2000, 32'h3, 32'h0, 5'd6, 32'h80FFFF7F, 0, 0, 0);
        run_txn("lbu",   1, 0, 2'b00, 1, 32'h2000, 32'h3, 32'h0, 5'd6, 32'h80FFFF7F, 1, 2, 0);
        run_txn("sh",    0, 1, 2'b01, 0, 32'h3000, 32'h2, 32'h0000ABCD, 5'd9, 32'h0, 0, 1, 0);
        run_txn("lw_mis",1, 0, 2'b10, 0, 32'h1000, 32'h1, 32'h0, 5'd5, 32'h0, 0, 0, 0);
        run_txn("sz11",  0, 1, 2'b11, 0, 32'h1000, 32'h0, 32'h0, 5'd5, 32'h0, 0, 0, 0);
        run_txn("lw_r0", 1, 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 5'd0, 32'h55AA55AA, 0, 0, 0);
        run_txn("ldst",  1, 1, 2'b01, 0, 32'h5000, 32'h2, 32'h0, 5'd3, 32'h9234ABCD, 2, 0, 1);
        run_txn("sb_wrap",0, 1, 2'b00, 0, 32'h1, 32'hFFFFFFFE, 32'h000000A5, 5'd1, 32'h0, 0, 0, 1);

        tmo_case(1'b0);
        run_txn("lw_post_tmo", 1, 0, 2'b10, 0, 32'h1000, 32'h4, 32'h0, 5'd5, 32'h01234567, 0, 0, 0);
        tmo_case(1'b1);
        rst_case(1'b1);
        rst_case(1'b0);
        run_txn("lw_post_rst", 1, 0, 2'b10, 0, 32'h7000, 32'hC, 32'h0, 5'd31, 32'hFEDCBA98, 1, 1, 0);

        for (int i = 0; i < 80; i++) begin
            bit ld;
            bit st;
            ld = 1'($urandom % 2);
            st = ld ? 1'($urandom % 2) : 1'b1;
            run_txn("rnd", ld, st, 2'($urandom % 4), 1'($urandom % 2), $urandom, $urandom,
                    $urandom, 5'($urandom % 32), $urandom, int'($urandom % 3),
                    int'($urandom % 3), 1'($urandom % 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit that consumes the execute-stage memory ops the ALU passes through untouched (mem_op != NOP, alu_op == NOP).
- Computes the effective address, drives a req/gnt/rvalid data-memory handshake, aligns store data and byte enables, and extracts/extends load data.
- Returns a writeback result and holds the pipeline stalled while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 256, cycles waited for dmem_gnt_i or dmem_rvalid_i before aborting with bus_err_o; 0 disables the timeout.
- DATA_W, 32, data/address width; only 32 supported.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid_i  input  1  memory op presented by execute
- req_ready_o  output  1  unit idle, can accept
- is_load_i  input  1  load op
- is_store_i  input  1  store op; is_load_i and is_store_i both high is treated as a load
- size_i  input  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned)
- unsigned_i  input  1  zero-extend loads (LBU/LHU)
- rs1_data_i  input  32  base register value
- rs2_data_i  input  32  store data
- imm_i  input  32  sign-extended offset
- rd_i  input  5  load destination register
- dmem_req_o  output  1  memory request
- dmem_we_o  output  1  write enable
- dmem_addr_o  output  32  word-aligned address, bits [1:0] = 0
- dmem_be_o  output  4  byte enables
- dmem_wdata_o  output  32  lane-aligned store data
- dmem_gnt_i  input  1  request accepted
- dmem_rvalid_i  input  1  response valid; given for both loads and stores
- dmem_rdata_i  input  32  load data
- stall_o  output  1  pipeline stall
- wb_valid_o  output  1  one-cycle completion pulse
- wb_rd_o  output  5  destination register
- wb_data_o  output  32  load result
- wb_wr_en_o  output  1  register-file write enable
- misaligned_o  output  1  one-cycle misaligned/illegal-size pulse
- bus_err_o  output  1  one-cycle timeout pulse

Behaviour:
- Reset values: FSM IDLE; req_ready_o=1; all other outputs 0.
- Reset is asynchronous: asserting rst mid-access drops dmem_req_o immediately.
- Any gnt/rvalid arriving after reset, or while IDLE, is ignored.
- Accept: req_valid_i && req_ready_o && (is_load_i || is_store_i) on a rising edge. Inputs are registered; a req_valid_i with neither op bit set is ignored.
- Address: ea = rs1_data_i + imm_i, mod 2^32 (wrap-around allowed); dmem_addr_o = {ea[31:2],2'b00}.
- Misaligned when: half with ea[0]=1, word with ea[1:0]!=0, or size_i=11.
- Misaligned accept → MISAL state for one cycle. That cycle: misaligned_o=1, wb_valid_o=1, wb_wr_en_o=0. No dmem_req_o is issued.
- Store alignment:
  - SB: wdata = byte replicated ×4, be = 1<<ea[1:0].
  - SH: wdata = half replicated ×2, be = ea[1] ? 1100 : 0011.
  - SW: be = 1111.
- Loads drive be for the accessed lanes; dmem_we_o=0.
- FSM:
  - IDLE: accept → REQ, or → MISAL.
  - REQ: dmem_req_o=1 with address/be/wdata held stable until dmem_gnt_i. gnt → WAIT.
  - WAIT: dmem_req_o=0. rvalid → RESP. gnt and rvalid in the same cycle are allowed; rvalid in that cycle is not sampled.
  - RESP: wb_valid_o=1 for one cycle → IDLE.
  - MISAL: one cycle → IDLE.
  - ABORT: one cycle → IDLE.
- Load result: dmem_rdata_i is captured on rvalid. Lane = ea[1:0] (byte) or ea[1] (half), sign- or zero-extended per unsigned_i.
- wb_wr_en_o = is_load && rd != 0 in the RESP cycle. Stores: wb_valid_o=1, wb_wr_en_o=0, wb_data_o=0.
- wb_rd_o and wb_data_o are valid only when wb_valid_o=1, else 0.
- stall_o = 1 in REQ and WAIT; combinationally also 1 in IDLE during an accept cycle. stall_o = 0 in RESP, MISAL, ABORT.
- req_ready_o = 1 only in IDLE.
- Minimum latency: accept edge to wb_valid_o is 3 cycles (gnt in the first REQ cycle, rvalid the next cycle).
- Timeout: a counter resets on entering REQ and on gnt, and counts each cycle in REQ/WAIT. Reaching TIMEOUT_CYCLES → ABORT.
- ABORT cycle: bus_err_o=1, wb_valid_o=1, wb_wr_en_o=0; dmem_req_o drops in ABORT.

Test Plan:
- LW: rs1=0x1000, imm=4, rdata=0xDEADBEEF, gnt at first REQ, rvalid next cycle → addr=0x1004, be=1111, wb_valid 3 cycles after accept, wb_data=0xDEADBEEF, rd=5, wr_en=1.
- LB/LBU: ea=0x2003, rdata=0x80FFFF7F → LB wb_data=0xFFFFFF80; LBU wb_data=0x00000080.
- SH: ea=0x3002, rs2=0x0000ABCD → addr=0x3000, be=1100, wdata=0xABCDABCD, we=1; wb_wr_en=0.
- LW with ea=0x1001 → no dmem_req_o, misaligned_o and wb_valid_o pulse together, wr_en=0, back to IDLE next cycle.
- gnt withheld TIMEOUT_CYCLES=4 cycles → bus_err_o pulse; a late gnt/rvalid afterwards is ignored; next LW completes normally.
- rst asserted while in WAIT → dmem_req_o, stall_o, wb_valid_o all 0 immediately, req_ready_o=1; a stray rvalid after reset produces no wb_valid_o. Also: load to rd=0 → wb_valid_o=1, wr_en=0.
